// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: two-flop synchronizer, stability-count debouncer,
// press/release edge pulses and a per-channel auto-repeat FSM.
module button_debounce #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_DELAY    = 12000000,
  parameter int REPEAT_PERIOD   = 4800000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_async,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DW   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [HW-1:0] RD_LAST   = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] RP_LAST   = HW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam logic [HW-1:0] H_MAX     = {HW{1'b1}};
  localparam logic          REPEAT_EN = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_HELD      = 2'd1,
    ST_REPEATING = 2'd2
  } state_t;

  logic [N_BTN-1:0] r_sync_meta;
  logic [N_BTN-1:0] r_sync;

  // Two-flop synchronizer; r_sync is the only view of the pins used downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_meta <= {N_BTN{1'b0}};
      r_sync      <= {N_BTN{1'b0}};
    end else begin
      r_sync_meta <= btn_async;
      r_sync      <= r_sync_meta;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic [DW-1:0] r_db_cnt;
    logic [DW-1:0] w_db_cnt_nxt;
    logic          w_accept;
    logic          r_level;
    logic          w_level_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_cnt_nxt;
    logic [HW-1:0] r_per_cnt;
    logic [HW-1:0] w_per_cnt_nxt;
    logic          r_press;
    logic          w_press_nxt;
    logic          r_release;
    logic          w_release_nxt;
    logic          r_repeat;
    logic          w_repeat_nxt;

    // Stability counter: any cycle agreeing with the level discards partial progress.
    always_comb begin
      w_accept     = 1'b0;
      w_db_cnt_nxt = {DW{1'b0}};
      if (r_sync[g] != r_level) begin
        if (r_db_cnt == DB_LAST) begin
          w_accept     = 1'b1;
          w_db_cnt_nxt = {DW{1'b0}};
        end else begin
          w_accept     = 1'b0;
          w_db_cnt_nxt = r_db_cnt + DW'(1);
        end
      end else begin
        w_db_cnt_nxt = {DW{1'b0}};
      end
      w_level_nxt = r_level ^ w_accept;
    end

    // Hold/repeat FSM; an accepted release always takes priority over a due repeat.
    always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_per_cnt_nxt  = r_per_cnt;
      w_press_nxt    = 1'b0;
      w_release_nxt  = 1'b0;
      w_repeat_nxt   = 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (w_accept) begin
            w_state_nxt    = ST_HELD;
            w_press_nxt    = 1'b1;
            w_hold_cnt_nxt = {HW{1'b0}};
          end else begin
            w_state_nxt = ST_RELEASED;
          end
        end
        ST_HELD: begin
          if (w_accept) begin
            w_state_nxt   = ST_RELEASED;
            w_release_nxt = 1'b1;
          end else if (REPEAT_EN && (r_hold_cnt == RD_LAST)) begin
            w_state_nxt   = ST_REPEATING;
            w_repeat_nxt  = 1'b1;
            w_per_cnt_nxt = {HW{1'b0}};
          end else if (r_hold_cnt != H_MAX) begin
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
          end else begin
            w_hold_cnt_nxt = r_hold_cnt;
          end
        end
        ST_REPEATING: begin
          if (w_accept) begin
            w_state_nxt   = ST_RELEASED;
            w_release_nxt = 1'b1;
          end else if (r_per_cnt == RP_LAST) begin
            w_repeat_nxt  = 1'b1;
            w_per_cnt_nxt = {HW{1'b0}};
          end else if (r_per_cnt != H_MAX) begin
            w_per_cnt_nxt = r_per_cnt + HW'(1);
          end else begin
            w_per_cnt_nxt = r_per_cnt;
          end
        end
        default: begin
          w_state_nxt    = ST_RELEASED;
          w_hold_cnt_nxt = {HW{1'b0}};
          w_per_cnt_nxt  = {HW{1'b0}};
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_db_cnt   <= {DW{1'b0}};
        r_level    <= 1'b0;
        r_state    <= ST_RELEASED;
        r_hold_cnt <= {HW{1'b0}};
        r_per_cnt  <= {HW{1'b0}};
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_db_cnt   <= w_db_cnt_nxt;
        r_level    <= w_level_nxt;
        r_state    <= w_state_nxt;
        r_hold_cnt <= w_hold_cnt_nxt;
        r_per_cnt  <= w_per_cnt_nxt;
        r_press    <= w_press_nxt;
        r_release  <= w_release_nxt;
        r_repeat   <= w_repeat_nxt;
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: a table of input steps plus hand-written corner sequences,
// with expected press/release events queued at drive time and a timing model for repeats.
module tb_button_debounce;

  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DB + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn;
  logic [1:0] lvl_a, prs_a, rls_a, rpt_a;
  logic [1:0] lvl_b, prs_b, rls_b, rpt_b;

  always #5 clk = ~clk;

  button_debounce #(
    .N_BTN(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_a (
    .clk(clk), .reset(reset), .btn_async(btn),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rls_a), .btn_repeat(rpt_a)
  );

  button_debounce #(
    .N_BTN(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
  ) u_dut_b (
    .clk(clk), .reset(reset), .btn_async(btn),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rls_b), .btn_repeat(rpt_b)
  );

  typedef struct {
    int         dut;
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;

  typedef struct {
    logic [1:0] btn;
    int         hold;
    logic [1:0] press;
    logic [1:0] rel;
  } vec_t;

  ev_t        sb_q[$];
  vec_t       tbl[10];
  int         cyc = 0;
  logic       rst_q = 1'b1;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] m_level[2];
  int         m_next_rpt[2][2];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic cmp(input string name, input int id, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%b exp=%b", name, id, cyc, got, exp);
    end
  endtask

  // Expected outputs this cycle: queued press/release events, repeats from the hold timing.
  task automatic check_dut(input int id, input int rd, input logic [1:0] lvl,
                           input logic [1:0] prs, input logic [1:0] rls, input logic [1:0] rpt);
    logic [1:0] e_p;
    logic [1:0] e_r;
    logic [1:0] e_t;
    e_p = 2'b00;
    e_r = 2'b00;
    e_t = 2'b00;
    if (rst_q) begin
      m_level[id] = 2'b00;
    end else begin
      for (int k = sb_q.size() - 1; k >= 0; k--) begin
        if (sb_q[k].dut == id && sb_q[k].cyc == cyc) begin
          e_p = e_p | sb_q[k].press;
          e_r = e_r | sb_q[k].rel;
          sb_q.delete(k);
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (e_p[ch]) begin
          m_level[id][ch]    = 1'b1;
          m_next_rpt[id][ch] = cyc + rd;
        end else if (e_r[ch]) begin
          m_level[id][ch] = 1'b0;
        end else if (rd > 0 && m_level[id][ch] && cyc == m_next_rpt[id][ch]) begin
          e_t[ch]            = 1'b1;
          m_next_rpt[id][ch] = cyc + RP;
        end
      end
    end
    cmp("level", id, lvl, m_level[id]);
    cmp("press", id, prs, e_p);
    cmp("release", id, rls, e_r);
    cmp("repeat", id, rpt, e_t);
  endtask

  always @(negedge clk) begin
    check_dut(0, RD, lvl_a, prs_a, rls_a, rpt_a);
    check_dut(1, 0, lvl_b, prs_b, rls_b, rpt_b);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the pulses a step driven now must produce LAT edges later, for both builds.
  task automatic expect_ev(input logic [1:0] p, input logic [1:0] r);
    ev_t e;
    for (int d = 0; d < 2; d++) begin
      e.dut   = d;
      e.cyc   = cyc + LAT;
      e.press = p;
      e.rel   = r;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    tbl[0] = '{2'b01,  8, 2'b01, 2'b00};
    tbl[1] = '{2'b00, 20, 2'b00, 2'b01};
    tbl[2] = '{2'b10, 50, 2'b10, 2'b00};
    tbl[3] = '{2'b00, 20, 2'b00, 2'b10};
    tbl[4] = '{2'b11, 20, 2'b11, 2'b00};
    tbl[5] = '{2'b01,  7, 2'b00, 2'b10};
    tbl[6] = '{2'b00, 30, 2'b00, 2'b01};
    tbl[7] = '{2'b01, 20, 2'b01, 2'b00};
    tbl[8] = '{2'b10, 20, 2'b10, 2'b01};
    tbl[9] = '{2'b00, 20, 2'b00, 2'b10};
    for (int d = 0; d < 2; d++) begin
      m_level[d] = 2'b00;
      for (int ch = 0; ch < 2; ch++) m_next_rpt[d][ch] = 0;
    end

    reset = 1'b1;
    btn   = 2'b00;
    tick(3);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      btn = tbl[i].btn;
      expect_ev(tbl[i].press, tbl[i].rel);
      tick(tbl[i].hold);
    end

    // Bounce 1,1,1,0 then steady 1; release lands exactly when the first repeat is due.
    btn = 2'b01;
    tick(3);
    btn = 2'b00;
    tick(1);
    btn = 2'b01;
    expect_ev(2'b01, 2'b00);
    tick(10);
    btn = 2'b00;
    expect_ev(2'b00, 2'b01);
    tick(20);

    // Isolated 3-cycle glitch on channel 1.
    btn = 2'b10;
    tick(3);
    btn = 2'b00;
    tick(15);

    // Reset mid-debounce, input gone by the time reset drops.
    btn = 2'b10;
    tick(3);
    reset = 1'b1;
    tick(2);
    btn   = 2'b00;
    reset = 1'b0;
    tick(15);

    // Reset mid-hold with the button kept down: counts as a fresh press.
    btn = 2'b01;
    expect_ev(2'b01, 2'b00);
    tick(8);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    expect_ev(2'b01, 2'b00);
    tick(30);
    btn = 2'b00;
    expect_ev(2'b00, 2'b01);
    tick(20);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_events got=%0d exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
